pool_window_feeder: RTL and testbench

Frame-side producer for the pooling layer. It accepts a 6-channel 8x8 feature map of 4-bit activations as a raster pixel stream and buffers the whole frame. It then issues the 16 non-overlapping 2x2 windows in raster-window order, one window per cycle, packed in the pooling layer's `data_in` format. A one-cycle `reset_storage` pulse precedes each frame's windows so the pooling result counter restarts at window 0.

---
 rtl/pool_pkg.sv | 28 ++
 rtl/pool_frame_buffer.sv | 30 +++
 rtl/pool_window_feeder.sv | 134 +++++++++++++
 tb/tb_pool_window_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared constants, FSM state type and window packing for the pooling front end.
// The pooling layer imports the same constants so both sides agree on data_in layout.
package pool_pkg;

   localparam int unsigned CH     = 6;
   localparam int unsigned DW     = 4;
   localparam int unsigned IMG    = 8;
   localparam int unsigned NWIN   = (IMG / 2) * (IMG / 2);
   localparam int unsigned NPIX   = IMG * IMG;
   localparam int unsigned PIX_AW = $clog2(NPIX);
   localparam int unsigned WIN_AW = $clog2(NWIN);
   localparam int unsigned CWW    = 4 * DW;

   typedef enum logic [1:0] {
      LOAD,
      CLEAR,
      EMIT,
      DONE
   } feed_state_t;

   function automatic logic [CWW-1:0] pack_window(input logic [DW-1:0] tl,
                                                  input logic [DW-1:0] tr,
                                                  input logic [DW-1:0] bl,
                                                  input logic [DW-1:0] br);
      return {br, bl, tr, tl};
   endfunction

endpackage

// File: rtl/pool_frame_buffer.sv
// Whole-frame pixel store: one write port, four combinational read ports
// so a full 2x2 window can be gathered in a single cycle.
module pool_frame_buffer
   import pool_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [PIX_AW-1:0]          waddr_i,
   input  logic [CH*DW-1:0]           wdata_i,
   input  logic [3:0][PIX_AW-1:0]     raddr_i,
   output logic [3:0][CH*DW-1:0]      rdata_o
);

   logic [CH*DW-1:0] mem_q [NPIX];

   // Contents are deliberately left unreset; every frame is fully rewritten before use.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         rdata_o[i] = mem_q[raddr_i[i]];
      end
   end

endmodule

// File: rtl/pool_window_feeder.sv
// Buffers one raster frame, then issues its 2x2 windows one per cycle,
// bracketed by a reset_storage pulse before and a frame_done pulse after.
module pool_window_feeder
   import pool_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [CH*DW-1:0]      pix_data,
   input  logic                  win_hold,
   output logic                  win_valid,
   output logic [CH*CWW-1:0]     win_data,
   output logic [WIN_AW-1:0]     win_idx,
   output logic                  reset_storage,
   output logic                  frame_done
);

   localparam int unsigned HALF = IMG / 2;

   feed_state_t               state_q, state_d;
   logic [PIX_AW-1:0]         p_q, p_d;
   logic [WIN_AW-1:0]         w_q, w_d;
   logic                      win_valid_q, win_valid_d;
   logic [CH*CWW-1:0]         win_data_q, win_data_d;
   logic [WIN_AW-1:0]         win_idx_q, win_idx_d;
   logic                      rs_q, rs_d;
   logic                      fd_q, fd_d;
   logic                      we;
   logic [3:0][PIX_AW-1:0]    raddr;
   logic [3:0][CH*DW-1:0]     rdata;
   int unsigned               base;

   // Top-left pixel of window w; the other three follow at +1, +IMG, +IMG+1.
   always_comb begin
      base     = (32'(w_q) / HALF) * (2 * IMG) + (32'(w_q) % HALF) * 2;
      raddr[0] = PIX_AW'(base);
      raddr[1] = PIX_AW'(base + 1);
      raddr[2] = PIX_AW'(base + IMG);
      raddr[3] = PIX_AW'(base + IMG + 1);
   end

   pool_frame_buffer u_buf (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (p_q),
      .wdata_i (pix_data),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= LOAD;
         p_q         <= '0;
         w_q         <= '0;
         win_valid_q <= 1'b0;
         win_data_q  <= '0;
         win_idx_q   <= '0;
         rs_q        <= 1'b0;
         fd_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         w_q         <= w_d;
         win_valid_q <= win_valid_d;
         win_data_q  <= win_data_d;
         win_idx_q   <= win_idx_d;
         rs_q        <= rs_d;
         fd_q        <= fd_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      w_d         = w_q;
      win_valid_d = 1'b0;
      win_data_d  = win_data_q;
      win_idx_d   = win_idx_q;
      rs_d        = 1'b0;
      fd_d        = 1'b0;
      we          = 1'b0;
      case (state_q)
         LOAD: begin
            if (pix_valid) begin
               we = 1'b1;
               if (p_q == PIX_AW'(NPIX - 1)) begin
                  p_d     = '0;
                  state_d = CLEAR;
               end else begin
                  p_d = p_q + 1'b1;
               end
            end
         end
         CLEAR: begin
            rs_d    = 1'b1;
            w_d     = '0;
            state_d = EMIT;
         end
         EMIT: begin
            if (!win_hold) begin
               win_valid_d = 1'b1;
               win_idx_d   = w_q;
               for (int unsigned c = 0; c < CH; c++) begin
                  win_data_d[c*CWW +: CWW] = pack_window(rdata[0][c*DW +: DW],
                                                         rdata[1][c*DW +: DW],
                                                         rdata[2][c*DW +: DW],
                                                         rdata[3][c*DW +: DW]);
               end
               if (w_q == WIN_AW'(NWIN - 1)) begin
                  w_d     = '0;
                  state_d = DONE;
               end else begin
                  w_d = w_q + 1'b1;
               end
            end
         end
         DONE: begin
            fd_d    = 1'b1;
            state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   assign pix_ready     = (state_q == LOAD);
   assign win_valid     = win_valid_q;
   assign win_data      = win_data_q;
   assign win_idx       = win_idx_q;
   assign reset_storage = rs_q;
   assign frame_done    = fd_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench for pool_window_feeder: the driver pushes expected windows,
// pulse edges and timing when a frame is loaded; the monitor pops and compares.
module tb_pool_window_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_valid = 1'b0;
   logic        win_hold = 1'b0;
   logic [23:0] pix_data = '0;
   logic        pix_ready;
   logic        win_valid;
   logic [95:0] win_data;
   logic [3:0]  win_idx;
   logic        reset_storage;
   logic        frame_done;

   always #5 clk = ~clk;

   pool_window_feeder dut (
      .clk           (clk),
      .rst           (rst),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .pix_data      (pix_data),
      .win_hold      (win_hold),
      .win_valid     (win_valid),
      .win_data      (win_data),
      .win_idx       (win_idx),
      .reset_storage (reset_storage),
      .frame_done    (frame_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // kind 0: channel c of pixel p = (p+c) mod 16; kind 1: all 0xF; else all 0.
   function automatic logic [23:0] pixel(input int kind, input int p);
      logic [23:0] v;
      v = '0;
      for (int c = 0; c < 6; c++) begin
         if (kind == 0)      v[c*4 +: 4] = 4'((p + c) % 16);
         else if (kind == 1) v[c*4 +: 4] = 4'hF;
         else                v[c*4 +: 4] = 4'h0;
      end
      return v;
   endfunction

   function automatic logic [95:0] window_of(input int kind, input int w);
      int r, k, tl;
      logic [23:0] a, b, cc, d;
      logic [95:0] v;
      r  = w / 4;
      k  = w % 4;
      tl = 2 * r * 8 + 2 * k;
      a  = pixel(kind, tl);
      b  = pixel(kind, tl + 1);
      cc = pixel(kind, tl + 8);
      d  = pixel(kind, tl + 9);
      v  = '0;
      for (int c = 0; c < 6; c++) begin
         v[c*16 +: 16] = {d[c*4 +: 4], cc[c*4 +: 4], b[c*4 +: 4], a[c*4 +: 4]};
      end
      return v;
   endfunction

   typedef struct {
      int          idx;
      logic [95:0] data;
      int          edge_n;
      int          kind;
   } win_exp_t;

   win_exp_t win_q[$];
   int       rs_q[$];
   int       fd_q[$];
   int       cyc = 0;
   int       acc_since = 0;
   int       fd_count = 0;
   bit       busy = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         acc_since = 0;
         busy      = 1'b0;
      end else if (pix_valid && pix_ready) begin
         acc_since++;
         if (acc_since == 64) busy = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (frame_done) begin
            fd_count++;
            if (fd_q.size() == 0) check_eq("fd_unexpected", frame_done, 0);
            else                  check_eq("fd_edge", cyc, fd_q.pop_front());
            check_eq("fd_ready", pix_ready, 1);
            busy      = 1'b0;
            acc_since = 0;
         end else if (busy) begin
            check_eq("ready_low", pix_ready, 0);
         end
         if (reset_storage) begin
            if (rs_q.size() == 0) check_eq("rs_unexpected", reset_storage, 0);
            else                  check_eq("rs_edge", cyc, rs_q.pop_front());
            check_eq("accepts", acc_since, 64);
         end
         if (win_valid) begin
            check_eq("win_excl", {reset_storage, frame_done}, 0);
            if (win_q.size() == 0) begin
               check_eq("win_unexpected", win_valid, 0);
            end else begin
               win_exp_t e;
               e = win_q.pop_front();
               check_eq("win_idx", win_idx, e.idx);
               check_eq("win_data", win_data, e.data);
               check_eq("win_edge", cyc, e.edge_n);
               if (e.kind == 0) begin
                  if (e.idx == 0) begin
                     check_eq("w0_ch0", win_data[15:0], 16'h9810);
                     check_eq("w0_ch1", win_data[31:16], 16'hA921);
                  end else if (e.idx == 5) begin
                     check_eq("w5_ch0", win_data[15:0], 16'hBA32);
                  end else if (e.idx == 15) begin
                     check_eq("w15_ch0", win_data[15:0], 16'hFE76);
                  end
               end
            end
         end
      end
   end

   task automatic send_frame(input int kind, input bit gaps, input int npix,
                             input int hold_w, input int hold_len, input bit keep,
                             output int first_edge);
      int p, ph, guard, e;
      bit acc;
      win_exp_t x;
      p = 0; ph = 0; guard = 0; first_edge = -1;
      @(posedge clk); #1;
      while (p < npix && guard < 2000) begin
         pix_valid = gaps ? (ph % 4 == 0 || ph % 4 == 3) : 1'b1;
         pix_data  = pixel(kind, p);
         @(negedge clk);
         acc = pix_valid && pix_ready;
         @(posedge clk); #1;
         if (acc) begin
            if (p == 0) first_edge = cyc;
            p++;
         end
         ph++;
         guard++;
      end
      if (p < npix) check_eq("load_timeout", p, npix);
      pix_valid = keep;
      if (npix == 64 && p == 64) begin
         e = cyc;
         rs_q.push_back(e + 1);
         for (int w = 0; w < 16; w++) begin
            x.idx    = w;
            x.data   = window_of(kind, w);
            x.edge_n = e + 2 + w + ((hold_w >= 0 && w >= hold_w) ? hold_len : 0);
            x.kind   = kind;
            win_q.push_back(x);
         end
         fd_q.push_back(e + 18 + ((hold_w >= 0) ? hold_len : 0));
         if (hold_w >= 0) begin
            repeat (1 + hold_w) @(posedge clk);
            #1 win_hold = 1'b1;
            repeat (hold_len) @(posedge clk);
            #1 win_hold = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input bit drop);
      int n;
      bit seen;
      n = 0; seen = 1'b0;
      while (!seen && n < 400) begin
         @(negedge clk);
         seen = frame_done;
         n++;
      end
      if (!seen) check_eq("done_timeout", seen, 1);
      if (drop) begin
         #1 pix_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input bit chk);
      rst       = 1'b0;
      pix_valid = 1'b0;
      win_hold  = 1'b0;
      #1;
      if (chk) begin
         check_eq("rst_ready", pix_ready, 1);
         check_eq("rst_valid", win_valid, 0);
         check_eq("rst_data", win_data, 0);
         check_eq("rst_idx", win_idx, 0);
         check_eq("rst_rs", reset_storage, 0);
         check_eq("rst_fd", frame_done, 0);
      end
      win_q.delete();
      rs_q.delete();
      fd_q.delete();
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      int fe_a, fe_b, fe_x, fd0, n;
      bit hit;
      repeat (2) @(negedge clk);
      check_eq("init_ready", pix_ready, 1);
      check_eq("init_valid", win_valid, 0);
      check_eq("init_data", win_data, 0);
      check_eq("init_idx", win_idx, 0);
      check_eq("init_rs", reset_storage, 0);
      check_eq("init_fd", frame_done, 0);
      #1 rst = 1'b1;

      send_frame(0, 1'b0, 64, -1, 0, 1'b0, fe_x);
      wait_done(1'b0);

      send_frame(0, 1'b1, 64, -1, 0, 1'b1, fe_x);
      wait_done(1'b1);

      send_frame(0, 1'b0, 64, 3, 2, 1'b0, fe_x);
      wait_done(1'b0);

      send_frame(0, 1'b0, 64, -1, 0, 1'b0, fe_x);
      n = 0; hit = 1'b0;
      while (!hit && n < 100) begin
         @(negedge clk);
         hit = win_valid && (win_idx == 4'd7);
         n++;
      end
      if (!hit) check_eq("idx7_timeout", hit, 1);
      do_reset(1'b1);
      send_frame(1, 1'b0, 64, -1, 0, 1'b0, fe_x);
      wait_done(1'b0);

      fd0 = fd_count;
      send_frame(0, 1'b0, 64, -1, 0, 1'b1, fe_a);
      send_frame(2, 1'b0, 64, -1, 0, 1'b0, fe_b);
      wait_done(1'b0);
      check_eq("period", fe_b - fe_a, 82);
      check_eq("fd_pulses", fd_count - fd0, 2);

      send_frame(0, 1'b0, 40, -1, 0, 1'b0, fe_x);
      do_reset(1'b0);
      send_frame(0, 1'b0, 64, -1, 0, 1'b0, fe_x);
      wait_done(1'b0);

      repeat (5) @(negedge clk);
      check_eq("sb_win_left", win_q.size(), 0);
      check_eq("sb_rs_left", rs_q.size(), 0);
      check_eq("sb_fd_left", fd_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
